// File: rtl/switch_debouncer.sv
// Debouncer for the switch-level inverter output: two-flop synchroniser,
// stability qualification, clean level, edge strobes and a saturating
// count of accepted transitions.
module switch_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_raw,
  input  logic             clr,
  output logic             db_out,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [SW-1:0]    STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic          s1;
  logic          s2;
  logic [SW-1:0] stab_cnt;
  logic          accept_c;

  // A candidate level is accepted on the cycle its qualification completes
  assign accept_c = (s2 != db_out) && (stab_cnt == STAB_LAST);

  // Two-flop synchroniser for the asynchronous raw level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= in_raw;
      s2 <= s1;
    end
  end

  // Stability counter: restarts whenever s2 agrees with the debounced level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_cnt <= '0;
    end else if (s2 == db_out || accept_c) begin
      stab_cnt <= '0;
    end else begin
      stab_cnt <= stab_cnt + SW'(1);
    end
  end

  // Debounced level and single-cycle strobes on an accepted transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_out <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= accept_c & s2;
      fall <= accept_c & ~s2;
      if (accept_c) begin
        db_out <= s2;
      end
    end
  end

  // Saturating transition counter; clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
    end else if (clr) begin
      edge_cnt <= '0;
    end else if (accept_c && edge_cnt != CNT_MAX) begin
      edge_cnt <= edge_cnt + CNT_W'(1);
    end
  end

  // Qualification in progress
  assign busy = (stab_cnt != '0);

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: default instance plus a
// 2-bit-counter instance sharing the same stimulus.
module tb_switch_debouncer;

  localparam int unsigned S = 4;

  logic       clk;
  logic       rst;
  logic       in_raw;
  logic       clr;
  logic       db_out, rise, fall, busy;
  logic [7:0] edge_cnt;
  logic       sat_db, sat_rise, sat_fall, sat_busy;
  logic [1:0] sat_cnt;

  int n_cmp;
  int n_bad;

  switch_debouncer #(.STABLE_CYCLES(S), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_raw(in_raw), .clr(clr),
    .db_out(db_out), .rise(rise), .fall(fall), .busy(busy), .edge_cnt(edge_cnt)
  );

  switch_debouncer #(.STABLE_CYCLES(S), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_raw(in_raw), .clr(clr),
    .db_out(sat_db), .rise(sat_rise), .fall(sat_fall), .busy(sat_busy), .edge_cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the level seen after the 2-cycle synchroniser delay is
  // kept as a history; the output flips once the last S observations all
  // disagree with it.
  bit mp0, mp1;
  bit hist[$];
  bit m_db, m_rise, m_fall, m_busy, m_acc, m_ev;
  int m_cnt8, m_cnt2;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mp0 = 1'b0; mp1 = 1'b0; hist.delete();
      m_db = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0;
      m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      m_ev = mp1;
      mp1 = mp0;
      mp0 = in_raw;
      hist.push_back(m_ev);
      if (hist.size() > S) void'(hist.pop_front());
      m_acc = (hist.size() == S);
      foreach (hist[i]) if (hist[i] == m_db) m_acc = 1'b0;
      m_rise = m_acc && !m_db;
      m_fall = m_acc && m_db;
      if (m_acc) m_db = !m_db;
      if (clr) begin
        m_cnt8 = 0; m_cnt2 = 0;
      end else if (m_acc) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      m_busy = !m_acc && (m_ev != m_db);
    end
  end

  task automatic test_reset();
    logic [15:0] obs;
    rst = 1'b1; in_raw = 1'b1; clr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      obs = {db_out, rise, fall, busy, edge_cnt, sat_db, sat_rise, sat_fall, sat_busy, sat_cnt};
      n_cmp++;
      if (obs !== 16'h0) begin
        n_bad++;
        $display("FAIL reset_hold k=%0d got %h want 0000", k, obs);
      end
      in_raw = 1'($urandom_range(0, 1));
      clr    = 1'($urandom_range(0, 1));
    end
    in_raw = 1'b1; clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({db_out, rise, fall, edge_cnt} !== {1'(k >= 6), 1'(k == 6), 1'b0, 8'(k >= 6 ? 1 : 0)}) begin
        n_bad++;
        $display("FAIL reset_release edge=%0d got db=%b r=%b f=%b cnt=%0d want db=%b r=%b f=0 cnt=%0d",
                 k, db_out, rise, fall, edge_cnt, k >= 6, k == 6, k >= 6 ? 1 : 0);
      end
    end
  endtask

  task automatic test_clean_edge();
    bit lvl;
    int exp_cnt;
    lvl = 1'b1;
    exp_cnt = 1;
    for (int t = 0; t < 3; t++) begin
      lvl = !lvl;
      in_raw = lvl;
      for (int k = 1; k <= 9; k++) begin
        @(negedge clk);
        if (k == 6) exp_cnt++;
        n_cmp++;
        if ({db_out, rise, fall, edge_cnt} !==
            {(k >= 6) ? lvl : !lvl, 1'(k == 6 && lvl), 1'(k == 6 && !lvl), 8'(exp_cnt)}) begin
          n_bad++;
          $display("FAIL clean_edge t=%0d edge=%0d got db=%b r=%b f=%b cnt=%0d want level=%b cnt=%0d",
                   t, k, db_out, rise, fall, edge_cnt, (k >= 6) ? lvl : !lvl, exp_cnt);
        end
      end
    end
  endtask

  task automatic test_glitch();
    bit seen_busy, seen_idle, start_db;
    start_db = m_db;
    seen_busy = 1'b0; seen_idle = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) in_raw = !in_raw;
      @(negedge clk);
      if (busy) seen_busy = 1'b1; else seen_idle = 1'b1;
      n_cmp++;
      if ({db_out, rise, fall, edge_cnt} !== {start_db, 1'b0, 1'b0, 8'(m_cnt8)}) begin
        n_bad++;
        $display("FAIL glitch k=%0d got db=%b r=%b f=%b cnt=%0d want db=%b r=0 f=0 cnt=%0d",
                 k, db_out, rise, fall, edge_cnt, start_db, m_cnt8);
      end
    end
    in_raw = start_db;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (!(seen_busy && seen_idle)) begin
      n_bad++;
      $display("FAIL glitch_busy got seen_busy=%b seen_idle=%b want 1 1", seen_busy, seen_idle);
    end
  endtask

  task automatic test_boundary();
    int nr, nf;
    logic [15:0] obs, expv;
    for (int w = 3; w <= 4; w++) begin
      nr = 0; nf = 0;
      in_raw = 1'b1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (k == w - 1) in_raw = 1'b0;
        nr += int'(rise); nf += int'(fall);
        obs  = {db_out, rise, fall, busy, edge_cnt, sat_db, sat_rise, sat_fall, sat_busy, sat_cnt};
        expv = {m_db, m_rise, m_fall, m_busy, 8'(m_cnt8), m_db, m_rise, m_fall, m_busy, 2'(m_cnt2)};
        n_cmp++;
        if (obs !== expv) begin
          n_bad++;
          $display("FAIL boundary_model w=%0d k=%0d got %h want %h", w, k, obs, expv);
        end
      end
      n_cmp++;
      if (nr != w - 3 || nf != w - 3) begin
        n_bad++;
        $display("FAIL boundary_pulse w=%0d got rises=%0d falls=%0d want %0d %0d", w, nr, nf, w - 3, w - 3);
      end
    end
  endtask

  task automatic test_saturation_clear();
    int seq[5] = '{1, 2, 3, 3, 3};
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int t = 0; t < 5; t++) begin
      in_raw = !in_raw;
      repeat (8) @(negedge clk);
      n_cmp++;
      if (sat_cnt !== 2'(seq[t])) begin
        n_bad++;
        $display("FAIL saturate t=%0d got cnt=%0d want %0d", t, sat_cnt, seq[t]);
      end
    end
    in_raw = !in_raw;
    repeat (5) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_cmp++;
    if ({sat_cnt, edge_cnt, rise | fall, sat_rise | sat_fall} !== {2'd0, 8'd0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL clear_priority got cnt2=%0d cnt8=%0d strobe=%b/%b want 0 0 1/1",
               sat_cnt, edge_cnt, rise | fall, sat_rise | sat_fall);
    end
  endtask

  task automatic test_mid_reset();
    in_raw = 1'b0;
    repeat (10) @(negedge clk);
    in_raw = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({busy, db_out} !== 2'b10) begin
      n_bad++;
      $display("FAIL midreset_pre got busy=%b db=%b want busy=1 db=0", busy, db_out);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, db_out, rise, fall, edge_cnt} !== 12'h0) begin
      n_bad++;
      $display("FAIL midreset_abort got busy=%b db=%b r=%b f=%b cnt=%0d want all 0",
               busy, db_out, rise, fall, edge_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({db_out, rise, edge_cnt} !== {1'(k >= 6), 1'(k == 6), 8'(k >= 6 ? 1 : 0)}) begin
        n_bad++;
        $display("FAIL midreset_requal edge=%0d got db=%b r=%b cnt=%0d want db=%b r=%b cnt=%0d",
                 k, db_out, rise, edge_cnt, k >= 6, k == 6, k >= 6 ? 1 : 0);
      end
    end
  endtask

  task automatic test_random();
    int run;
    logic [15:0] obs, expv;
    run = 0;
    for (int k = 0; k < 400; k++) begin
      if (run == 0) begin
        in_raw = !in_raw;
        run = int'($urandom_range(1, 8));
      end
      run--;
      clr = ($urandom_range(0, 29) == 0);
      @(negedge clk);
      obs  = {db_out, rise, fall, busy, edge_cnt, sat_db, sat_rise, sat_fall, sat_busy, sat_cnt};
      expv = {m_db, m_rise, m_fall, m_busy, 8'(m_cnt8), m_db, m_rise, m_fall, m_busy, 2'(m_cnt2)};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL random k=%0d got %h want %h", k, obs, expv);
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; in_raw = 1'b0; clr = 1'b0;
    test_reset();
    test_clean_edge();
    test_glitch();
    test_boundary();
    test_saturation_clear();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
Downstream consumer of the switch-level inverter stage (`switch`). It takes that stage's `out` wire as an asynchronous raw input and synchronises it into the `clk` domain. It filters out pulses shorter than STABLE_CYCLES and produces a clean level, single-cycle rise/fall strobes, and a saturating transition counter. This gives the switch-level stage a registered, glitch-free handoff into RTL logic.

Parameters:
STABLE_CYCLES, 4, consecutive clk cycles the synchronised input must differ from db_out before db_out follows it; legal range >= 1.
CNT_W, 8, width of edge_cnt.

Ports:
clk  input  1  system clock, rising-edge active.
rst  input  1  reset, asynchronous, active-high.
in_raw  input  1  raw level from the switch stage output; asynchronous to clk.
clr  input  1  synchronous clear of edge_cnt.
db_out  output  1  debounced level.
rise  output  1  one-cycle strobe when db_out goes 0->1.
fall  output  1  one-cycle strobe when db_out goes 1->0.
busy  output  1  high while a candidate transition is being qualified (stab_cnt != 0).
edge_cnt  output  CNT_W  number of accepted transitions; saturates.

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high; while rst=1 every flop is 0.
  - Reset values: s1, s2, stab_cnt, db_out, rise, fall, edge_cnt are all 0; busy=0.
  - Asserting rst mid-qualification aborts it immediately; no strobe is produced.
- Synchroniser: two flops, s1<=in_raw, s2<=s1. No logic between them.
- Stability counter stab_cnt, width clog2(STABLE_CYCLES)+1, evaluated each rising edge:
  - If s2==db_out: stab_cnt<=0.
  - Else if stab_cnt==STABLE_CYCLES-1: db_out<=s2 and stab_cnt<=0. Set rise<=s2 and fall<=~s2 (accepted transition).
  - Else: stab_cnt<=stab_cnt+1.
- Strobes: rise and fall are registered and high for exactly one cycle, coincident with the first cycle db_out shows the new value. They are never high together, and they are 0 on every cycle without an accepted transition.
- Latency: in_raw changes before edge E0 and then holds. db_out changes after edge E0+STABLE_CYCLES+1, i.e. STABLE_CYCLES+2 rising edges including E0. With the default, that is 6 edges.
- Glitch rejection: if s2 returns to db_out before the count completes, stab_cnt returns to 0 and nothing changes. A pulse on s2 shorter than STABLE_CYCLES cycles is never propagated.
- edge_cnt update:
  - +1 on every accepted transition.
  - Holds at 2^CNT_W-1 (no wrap).
  - clr=1 forces 0 on the next edge; clr has priority over a simultaneous increment, so the result is 0.
- busy = (stab_cnt != 0), combinational from the register.
- Post-reset with in_raw held at 1: this is treated as a genuine transition. db_out rises 6 edges after rst deasserts, rise pulses, and edge_cnt becomes 1.
- STABLE_CYCLES=1: db_out follows s2 one edge after s2 differs (total latency 3 edges). Strobes and counting are unchanged.

Test Plan:
- Reset: rst=1 with in_raw=1 and clr=0 at random -> all outputs 0 throughout. Release rst -> db_out=1 and rise=1 on the 6th edge, edge_cnt=1.
- Clean edge: clk 10 ns period, in_raw 0->1 then held, default params -> db_out high after 6 edges, rise high exactly 1 cycle, fall=0, edge_cnt 0->1. Then in_raw 1->0 held -> fall for 1 cycle, edge_cnt=2.
- Glitch filter: drive in_raw from `switch` with its input toggling every 10 ns and clk 5 ns period (in_raw changes every 2 cycles) -> db_out never changes, rise/fall never assert, busy toggles, edge_cnt stays 0.
- Boundary pulse: in_raw high for exactly 3 cycles -> no change. High for exactly 4 cycles -> db_out rises, then falls after the return, edge_cnt=2.
- Saturation and clear: CNT_W=2, 5 accepted transitions -> edge_cnt sequence 1,2,3,3,3. Assert clr on the cycle of a 6th transition -> edge_cnt=0, and the strobe still fires.
- Mid-operation reset: assert rst while stab_cnt=2 -> stab_cnt=0, busy=0, no strobe. After release, the transition re-qualifies from scratch, 6 edges.
